// File: rtl/f1_start_ctrl.sv
// ----------------------------------------------------------------------------
// f1_start_ctrl
//   Sequencer for the F1 start-lights reaction game. A free-running 7-bit
//   LFSR (x^7+x^3+1) supplies the random hold length. On a trigger the lights
//   fill one per tick, hold for a random number of ticks, go dark, and the
//   player's reaction time is then counted in clock cycles.
//
// Ports
//   clk          system clock, all state on posedge
//   rst_n        asynchronous active-low reset
//   trigger      start request, honoured only while idle
//   react        player button (synchronous level)
//   lights       light bar, bit0 lights first
//   busy         high whenever the sequencer is not idle
//   delay_val    LFSR value captured as the hold length in ticks
//   react_cnt    reaction time in clk cycles, held until the next start
//   react_valid  1-cycle pulse: react_cnt is valid
//   false_start  1-cycle pulse: react pressed before the lights went off
// ----------------------------------------------------------------------------
module f1_start_ctrl #(
    parameter int unsigned N_LIGHTS = 8,
    parameter int unsigned TICK_DIV = 24,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                trigger,
    input  logic                react,
    output logic [N_LIGHTS-1:0] lights,
    output logic                busy,
    output logic [6:0]          delay_val,
    output logic [CNT_W-1:0]    react_cnt,
    output logic                react_valid,
    output logic                false_start
);

    localparam int unsigned TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LIGHTS = 2'd1,
        DELAY  = 2'd2,
        TIMING = 2'd3
    } state_t;

    state_t              r_state;
    logic [6:0]          r_lfsr;
    logic [TW-1:0]       r_tick_cnt;
    logic [6:0]          r_hold;
    logic [N_LIGHTS-1:0] r_lights;
    logic                r_busy;
    logic [6:0]          r_delay_val;
    logic [CNT_W-1:0]    r_react_cnt;
    logic                r_react_valid;
    logic                r_false_start;

    logic                w_tick;
    logic [N_LIGHTS-1:0] w_lights_next;
    logic                w_cnt_sat;

    assign w_tick        = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_lights_next = {r_lights[N_LIGHTS-2:0], 1'b1};
    assign w_cnt_sat     = &r_react_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_lfsr        <= 7'h01;
            r_tick_cnt    <= '0;
            r_hold        <= '0;
            r_lights      <= '0;
            r_busy        <= 1'b0;
            r_delay_val   <= '0;
            r_react_cnt   <= '0;
            r_react_valid <= 1'b0;
            r_false_start <= 1'b0;
        end else begin
            r_lfsr        <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[2]};
            r_react_valid <= 1'b0;
            r_false_start <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (trigger) begin
                        r_state     <= LIGHTS;
                        r_busy      <= 1'b1;
                        r_lights    <= '0;
                        r_react_cnt <= '0;
                        r_tick_cnt  <= '0;
                    end
                end

                LIGHTS: begin
                    // A press before lights-out beats any tick in the same cycle
                    if (react) begin
                        r_false_start <= 1'b1;
                        r_lights      <= '0;
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                    end else begin
                        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
                        if (w_tick) begin
                            r_lights <= w_lights_next;
                            if (&w_lights_next) begin
                                r_delay_val <= r_lfsr;
                                r_hold      <= r_lfsr;
                                r_state     <= DELAY;
                            end
                        end
                    end
                end

                DELAY: begin
                    if (react) begin
                        r_false_start <= 1'b1;
                        r_lights      <= '0;
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                    end else begin
                        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
                        if (w_tick) begin
                            // LFSR is never zero, so hold always reaches 1
                            if (r_hold == 7'd1) begin
                                r_lights    <= '0;
                                r_react_cnt <= '0;
                                r_state     <= TIMING;
                            end else begin
                                r_hold <= r_hold - 7'd1;
                            end
                        end
                    end
                end

                TIMING: begin
                    // The press cycle itself counts toward the reaction time
                    if (react) begin
                        r_react_valid <= 1'b1;
                        if (!w_cnt_sat) r_react_cnt <= r_react_cnt + 1'b1;
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                    end else if (w_cnt_sat) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_react_cnt <= r_react_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign lights      = r_lights;
    assign busy        = r_busy;
    assign delay_val   = r_delay_val;
    assign react_cnt   = r_react_cnt;
    assign react_valid = r_react_valid;
    assign false_start = r_false_start;

endmodule

// File: tb/tb_f1_start_ctrl.sv
// ----------------------------------------------------------------------------
// tb_f1_start_ctrl
//   Directed bench for f1_start_ctrl with N_LIGHTS=8, TICK_DIV=2, CNT_W=16.
// ----------------------------------------------------------------------------
module tb_f1_start_ctrl;

    logic        clk;
    logic        rst_n;
    logic        trigger;
    logic        react;
    logic [7:0]  lights;
    logic        busy;
    logic [6:0]  delay_val;
    logic [15:0] react_cnt;
    logic        react_valid;
    logic        false_start;

    int unsigned total;
    int unsigned bad;

    logic [6:0]  m_lfsr;
    logic [6:0]  dv_exp;
    logic [7:0]  exp_l;
    logic [6:0]  lfsr_tab [5];
    logic        saw_pulse;
    int unsigned n_cyc;

    f1_start_ctrl #(
        .N_LIGHTS (8),
        .TICK_DIV (2),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trigger     (trigger),
        .react       (react),
        .lights      (lights),
        .busy        (busy),
        .delay_val   (delay_val),
        .react_cnt   (react_cnt),
        .react_valid (react_valid),
        .false_start (false_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^7+x^3+1, seed 01, advances every clock
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 7'h01;
        else        m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step until lights match, bounded; an expired bound is a failed check
    task automatic wait_lights(input string tag, input logic [7:0] exp, input int unsigned bound);
        for (int unsigned i = 0; i < bound && lights !== exp; i++) step();
        chk(tag, {24'd0, lights}, {24'd0, exp});
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_lights"}, {24'd0, lights}, 32'd0);
        chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
        chk({tag, "_dv"},     {25'd0, delay_val}, 32'd0);
        chk({tag, "_cnt"},    {16'd0, react_cnt}, 32'd0);
        chk({tag, "_valid"},  {31'd0, react_valid}, 32'd0);
        chk({tag, "_fs"},     {31'd0, false_start}, 32'd0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        trigger = 1'b0;
        react   = 1'b0;
        lfsr_tab[0] = 7'h01; lfsr_tab[1] = 7'h02; lfsr_tab[2] = 7'h04;
        lfsr_tab[3] = 7'h09; lfsr_tab[4] = 7'h12;

        // 1: reset and LFSR sequence
        #23;
        rst_n = 1'b1;
        #1;
        chk_idle_zero("rst");
        for (int unsigned i = 0; i < 5; i++) begin
            chk("lfsr_seq", {25'd0, dut.r_lfsr}, {25'd0, lfsr_tab[i]});
            chk("lfsr_model", {25'd0, m_lfsr}, {25'd0, lfsr_tab[i]});
            step();
        end
        // react and idle are ignored when idle
        react = 1'b1;
        step(); step();
        react = 1'b0;
        chk("idle_react_busy",  {31'd0, busy}, 32'd0);
        chk("idle_react_valid", {31'd0, react_valid}, 32'd0);
        chk("idle_react_fs",    {31'd0, false_start}, 32'd0);

        // 2: light sequence, capture and hold length
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("t2_busy", {31'd0, busy}, 32'd1);
        chk("t2_l0", {24'd0, lights}, 32'd0);
        exp_l  = 8'h00;
        dv_exp = 7'h00;
        for (int unsigned i = 0; i < 8; i++) begin
            step();
            chk("t2_lights_hold", {24'd0, lights}, {24'd0, exp_l});
            if (i == 7) dv_exp = m_lfsr;
            step();
            exp_l = {exp_l[6:0], 1'b1};
            chk("t2_lights_step", {24'd0, lights}, {24'd0, exp_l});
        end
        chk("t2_delay_val", {25'd0, delay_val}, {25'd0, dv_exp});
        for (int unsigned i = 0; i < 2 * dv_exp - 1; i++) step();
        chk("t2_hold_lit", {24'd0, lights}, 32'h0000_00FF);
        step();
        chk("t2_lights_off", {24'd0, lights}, 32'd0);
        chk("t2_busy_timing", {31'd0, busy}, 32'd1);

        // 3: react on the fifth cycle after lights-out
        step(); step(); step(); step();
        chk("t3_cnt4", {16'd0, react_cnt}, 32'd4);
        react = 1'b1;
        step();
        react = 1'b0;
        chk("t3_valid", {31'd0, react_valid}, 32'd1);
        chk("t3_cnt",   {16'd0, react_cnt}, 32'd5);
        chk("t3_busy",  {31'd0, busy}, 32'd0);
        chk("t3_fs",    {31'd0, false_start}, 32'd0);
        step();
        chk("t3_pulse_end", {31'd0, react_valid}, 32'd0);
        chk("t3_cnt_held",  {16'd0, react_cnt}, 32'd5);

        // 4: false start while lights=0x07
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        chk("t4_cnt_clr", {16'd0, react_cnt}, 32'd0);
        for (int unsigned i = 0; i < 6; i++) step();
        chk("t4_l07", {24'd0, lights}, 32'h0000_0007);
        react = 1'b1;
        step();
        react = 1'b0;
        chk("t4_fs",     {31'd0, false_start}, 32'd1);
        chk("t4_lights", {24'd0, lights}, 32'd0);
        chk("t4_busy",   {31'd0, busy}, 32'd0);
        chk("t4_valid",  {31'd0, react_valid}, 32'd0);
        step();
        chk("t4_fs_end", {31'd0, false_start}, 32'd0);
        chk("t4_valid2", {31'd0, react_valid}, 32'd0);

        // 5: timeout saturates the counter without a pulse
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        wait_lights("t5_full", 8'hFF, 40);
        wait_lights("t5_off", 8'h00, 400);
        saw_pulse = 1'b0;
        n_cyc     = 0;
        while (busy === 1'b1 && n_cyc < 70000) begin
            step();
            n_cyc++;
            if (react_valid === 1'b1 || false_start === 1'b1) saw_pulse = 1'b1;
        end
        chk("t5_cycles", n_cyc, 32'd65536);
        chk("t5_busy",  {31'd0, busy}, 32'd0);
        chk("t5_cnt",   {16'd0, react_cnt}, 32'h0000_FFFF);
        chk("t5_pulse", {31'd0, saw_pulse}, 32'd0);

        // 6: asynchronous reset during DELAY, then a clean run
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        wait_lights("t6_full", 8'hFF, 40);
        step();
        chk("t6_in_delay", {31'd0, busy}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle_zero("t6_rst");
        chk("t6_lfsr_rst", {25'd0, dut.r_lfsr}, 32'h0000_0001);
        #2;
        rst_n = 1'b1;
        step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        wait_lights("t6_refull", 8'hFF, 40);
        wait_lights("t6_reoff", 8'h00, 400);
        step(); step();
        react = 1'b1;
        step();
        react = 1'b0;
        chk("t6_valid", {31'd0, react_valid}, 32'd1);
        chk("t6_cnt",   {16'd0, react_cnt}, 32'd3);
        chk("t6_busy",  {31'd0, busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
